// File: rtl/sc_window_accumulator.sv
// Window accumulator: sums clamped per-cycle popcounts over 2^LOG_L accepted samples
// and presents each window total through a single-entry valid/ready output register.
module sc_window_accumulator #(
  parameter int K     = 3,
  parameter int LOG_L = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [K+1:0]       count_in,
  output logic [K+LOG_L:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               overrun
);

  localparam int CW = K + 2;
  localparam int DW = K + LOG_L + 1;
  localparam logic [CW-1:0]    N_VAL     = CW'(1 << K);
  localparam logic [LOG_L-1:0] LAST_SLOT = '1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  state_t            state_reg, state_next;
  logic [DW-1:0]     acc_reg, acc_next;
  logic [LOG_L-1:0]  sample_cnt_reg, sample_cnt_next;
  logic [DW-1:0]     out_data_reg, out_data_next;
  logic              out_valid_reg, out_valid_next;
  logic              overrun_reg, overrun_next;

  logic [CW-1:0]     count_clamped;
  logic [DW-1:0]     candidate;
  logic              accept;
  logic              window_done;
  logic              out_free;

  // Out-of-range popcounts saturate at N rather than flagging an error.
  assign count_clamped = (count_in > N_VAL) ? N_VAL : count_in;
  assign candidate     = acc_reg + DW'(count_clamped);

  assign accept      = (state_reg == ACCUM) && en && !flush && in_valid;
  assign window_done = accept && (sample_cnt_reg == LAST_SLOT);
  assign out_free    = !out_valid_reg || out_ready;

  always_comb begin
    state_next      = en ? ACCUM : IDLE;
    acc_next        = acc_reg;
    sample_cnt_next = sample_cnt_reg;

    if (!en || state_reg == IDLE) begin
      acc_next        = '0;
      sample_cnt_next = '0;
    end else if (flush) begin
      acc_next        = '0;
      sample_cnt_next = '0;
    end else if (accept) begin
      // Completion restarts the window on the same edge, so there is no gap cycle.
      if (window_done) begin
        acc_next        = '0;
        sample_cnt_next = '0;
      end else begin
        acc_next        = candidate;
        sample_cnt_next = sample_cnt_reg + 1'b1;
      end
    end
  end

  always_comb begin
    out_data_next  = out_data_reg;
    out_valid_next = out_valid_reg;
    overrun_next   = overrun_reg;

    if (out_valid_reg && out_ready) begin
      out_valid_next = 1'b0;
    end

    // A consume and a load may share an edge; the new total replaces the consumed one.
    if (window_done) begin
      if (out_free) begin
        out_data_next  = candidate;
        out_valid_next = 1'b1;
      end else begin
        overrun_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      acc_reg        <= '0;
      sample_cnt_reg <= '0;
      out_data_reg   <= '0;
      out_valid_reg  <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      acc_reg        <= acc_next;
      sample_cnt_reg <= sample_cnt_next;
      out_data_reg   <= out_data_next;
      out_valid_reg  <= out_valid_next;
      overrun_reg    <= overrun_next;
    end
  end

  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;
  assign overrun   = overrun_reg;

endmodule

// File: tb/tb_sc_window_accumulator.sv
// Directed bench for sc_window_accumulator with K=3, LOG_L=2 (N=8, L=4, 6-bit totals).
module tb_sc_window_accumulator;

  localparam int K     = 3;
  localparam int LOG_L = 2;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic             flush;
  logic             in_valid;
  logic [K+1:0]     count_in;
  logic [K+LOG_L:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             overrun;

  int n_checks;
  int n_pass;

  sc_window_accumulator #(.K(K), .LOG_L(LOG_L)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .flush     (flush),
    .in_valid  (in_valid),
    .count_in  (count_in),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) begin
      n_pass++;
      $display("check %s: got %0d expected %0d ok", tag, got, exp);
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input int v);
    in_valid = 1'b1;
    count_in = v[K+1:0];
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    en        = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    count_in  = '0;
    out_ready = 1'b0;

    // Reset state
    do_reset();
    check("rst_valid", int'(out_valid), 0);
    check("rst_data", int'(out_data), 0);
    check("rst_overrun", int'(overrun), 0);

    // Basic sum 3+5+8+0 = 16; first edge with en=1 only enters ACCUM
    en = 1'b1;
    out_ready = 1'b1;
    tick();
    sample(3); sample(5); sample(8);
    check("basic_not_early", int'(out_valid), 0);
    sample(0);
    check("basic_valid", int'(out_valid), 1);
    check("basic_data", int'(out_data), 16);
    check("basic_overrun", int'(overrun), 0);
    tick();
    check("basic_consumed", int'(out_valid), 0);

    // Full scale, then clamp of 12 to 8, back-to-back windows
    for (int i = 0; i < 4; i++) sample(8);
    check("full_valid", int'(out_valid), 1);
    check("full_data", int'(out_data), 32);
    sample(12);
    check("clamp_consumed_mid", int'(out_valid), 0);
    for (int i = 0; i < 3; i++) sample(12);
    check("clamp_valid", int'(out_valid), 1);
    check("clamp_data", int'(out_data), 32);
    tick();

    // Gaps and flush: the flushed partial (and its same-cycle sample) never appears
    sample(2);
    tick(); tick();
    sample(2);
    flush = 1'b1;
    sample(5);
    flush = 1'b0;
    sample(1); sample(1); sample(1);
    check("flush_no_early", int'(out_valid), 0);
    sample(1);
    check("flush_valid", int'(out_valid), 1);
    check("flush_data", int'(out_data), 4);
    tick();

    // Backpressure: second window dropped, first result held
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) sample(1);
    check("bp_first_data", int'(out_data), 4);
    check("bp_first_overrun", int'(overrun), 0);
    for (int i = 0; i < 4; i++) sample(2);
    check("bp_held_valid", int'(out_valid), 1);
    check("bp_held_data", int'(out_data), 4);
    check("bp_overrun", int'(overrun), 1);
    out_ready = 1'b1;
    tick();
    check("bp_drained", int'(out_valid), 0);
    check("bp_overrun_sticky", int'(overrun), 1);

    // Simultaneous consume and complete, after reset clears overrun
    do_reset();
    check("rst2_overrun", int'(overrun), 0);
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) sample(1);
    check("sim_hold_data", int'(out_data), 4);
    sample(3); sample(3); sample(3);
    out_ready = 1'b1;
    sample(3);
    check("sim_valid", int'(out_valid), 1);
    check("sim_data", int'(out_data), 12);
    check("sim_overrun", int'(overrun), 0);
    tick();
    check("sim_consumed", int'(out_valid), 0);

    // en drop discards partial window; samples while en=0 are ignored
    sample(1); sample(1);
    en = 1'b0;
    sample(8);
    en = 1'b1;
    tick();
    out_ready = 1'b0;
    sample(1); sample(1); sample(1);
    check("en_no_early", int'(out_valid), 0);
    sample(1);
    check("en_valid", int'(out_valid), 1);
    check("en_data", int'(out_data), 4);

    // Pending result survives IDLE, then reset drops it without overrun
    en = 1'b0;
    tick();
    check("idle_hold_valid", int'(out_valid), 1);
    do_reset();
    check("rst3_valid", int'(out_valid), 0);
    check("rst3_data", int'(out_data), 0);
    check("rst3_overrun", int'(overrun), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sc_window_accumulator.md
# sc_window_accumulator

Downstream stage of the parallel bit counter in the stochastic-computing datapath. It sums the per-cycle popcounts of an N-lane bitstream over a fixed window of L = 2^LOG_L accepted samples. At the end of each window it presents the binary total through a valid/ready output register. The result is the stochastic-to-binary conversion: value ≈ total / (N·L).

## Interface
Parameters:
- K, 3, lane-count exponent; N = 2^K lanes, matches the upstream counter.
- LOG_L, 8, window-length exponent; window L = 2^LOG_L accepted samples, LOG_L ≥ 1.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst_n  input  1  reset; one clock, synchronous and active-low.
- en  input  1  enable; low forces IDLE and discards any partial window.
- flush  input  1  restart the current window, discarding the partial sum.
- in_valid  input  1  count_in is a sample this cycle.
- count_in  input  K+2  popcount from upstream, legal range 0..N.
- out_data  output  K+LOG_L+1  window total, max N·L.
- out_valid  output  1  out_data holds an unconsumed result.
- out_ready  input  1  consumer accepts out_data.
- overrun  output  1  sticky flag: a completed window was dropped.

## Operation
- States:
  - IDLE: entered from reset, or whenever en=0.
  - ACCUM: entered when en=1.
- IDLE→ACCUM on the first edge with en=1. ACCUM→IDLE on any edge with en=0.
- Entering or leaving IDLE clears acc and sample_cnt.
- Registers:
  - acc: K+LOG_L+1 bits.
  - sample_cnt: LOG_L bits, wraps.
  - out_data, out_valid, overrun.
- Clamp: if count_in > N, the value N is used instead. No error flag.
- Each accepted sample (state ACCUM, in_valid=1, flush=0) adds the clamped count to acc and increments sample_cnt.
- Window completion: an accepted sample arrives with sample_cnt = L−1. On that edge:
  - candidate total = acc + clamped count_in;
  - acc ← 0 and sample_cnt ← 0, so the next window starts with no gap cycle.
- Output load: the candidate is written to out_data and out_valid ← 1 if the output register is free. It is free if out_valid=0, or if out_valid=1 and out_ready=1 on the same edge.
- Otherwise the candidate is dropped, out_data and out_valid are unchanged, and overrun ← 1.
- Handshake: out_valid=1 and out_ready=1 at an edge consumes the result. out_valid falls unless a new load occurs on the same edge. out_data is stable while out_valid=1 and not consumed.
- flush=1 in ACCUM: acc ← 0 and sample_cnt ← 0. The same-cycle sample is discarded. Output register and overrun are untouched.
- Priority per edge: rst_n low > en low > flush > sample accept.
- overrun clears only on reset.
- en and flush do not affect out_valid, out_data or overrun. A pending result stays available for handshake in IDLE.
- Arithmetic is unsigned and cannot overflow: the maximum, N·L = 2^(K+LOG_L), fits in K+LOG_L+1 bits.

## Timing
- Reset values on the edge with rst_n=0: state IDLE, acc 0, sample_cnt 0, out_data 0, out_valid 0, overrun 0.
- Latency: out_valid is high in the cycle after the edge that accepts the L-th sample (1-cycle latency).
- Throughput: one sample per cycle, continuous back-to-back windows, with no bubble when out_ready is high.
- First accept: with en rising at edge t, the earliest accepted sample is at edge t+1; the cycle after reset is IDLE.
- Reset mid-window or with out_valid=1: everything clears and the pending result is lost with no overrun.
- out_ready is ignored while out_valid=0.

## Test plan
Use K=3, LOG_L=2 (N=8, L=4, out_data 6 bits).
- Basic sum: reset, en=1, out_ready=1, count_in=3,5,8,0 with in_valid=1 → out_valid=1 one cycle after 4th sample, out_data=16, overrun=0.
- Full scale and clamp: 4 samples of count_in=8, then a window with count_in=12 ×4 → out_data=32 both times; no wrap.
- Gaps and flush: samples 2, in_valid=0 two cycles, 2, flush, then 1,1,1,1 → single result 4; the flushed partial never appears.
- Backpressure: out_ready=0, run two full windows of 1s and 2s → out_data stays 4, overrun=1 after the 2nd window; raise out_ready → one transfer of 4, out_valid falls.
- Simultaneous consume and complete: out_valid=1 holding 4; the edge with out_ready=1 also completes a window of 3s → out_data=12, out_valid stays 1, overrun stays 0.
- en drop and reset: en=0 after 2 samples, then en=1 with 4 samples of 1 → result 4. Then rst_n=0 while out_valid=1 → the following cycle out_valid=0, out_data=0, overrun=0.
